// File: rtl/pa_regfile_pkg.sv
// Shared defaults, clear-FSM state type and physical-index helper for the banked register file.
package pa_regfile_pkg;

  localparam int unsigned DefDataWidth   = 16;
  localparam int unsigned DefRegsPerBank = 16;
  localparam int unsigned DefBankBits    = 6;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } clr_state_e;

  // Flat word index of register regi inside frame bank.
  function automatic int unsigned phys_idx(input int unsigned bank,
                                           input int unsigned regi,
                                           input int unsigned regs_per_bank);
    return bank * regs_per_bank + regi;
  endfunction

endpackage

// File: rtl/frame_clear_fsm.sv
// Tracks the selected frame, detects pushes and sequences the zero-fill of a newly entered frame.
module frame_clear_fsm
  import pa_regfile_pkg::*;
#(
  parameter int unsigned REGS_PER_BANK = DefRegsPerBank,
  parameter int unsigned BANK_BITS     = DefBankBits,
  parameter int unsigned REG_BITS      = $clog2(REGS_PER_BANK)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [BANK_BITS-1:0] bank_i,
  output logic                 clr_we_o,
  output logic [BANK_BITS-1:0] clr_bank_o,
  output logic [REG_BITS-1:0]  clr_idx_o,
  output logic                 busy_o
);

  clr_state_e           state_q, state_d;
  logic [BANK_BITS-1:0] prev_bank_q;
  logic [BANK_BITS-1:0] clr_bank_q, clr_bank_d;
  logic [REG_BITS-1:0]  clr_idx_q, clr_idx_d;
  logic                 push, change, last;

  // Modular compare so 63 -> 0 also counts as a push.
  assign push   = (bank_i == prev_bank_q + BANK_BITS'(1));
  assign change = (bank_i != prev_bank_q);
  assign last   = (clr_idx_q == REG_BITS'(REGS_PER_BANK - 1));

  always_comb begin
    state_d    = state_q;
    clr_bank_d = clr_bank_q;
    clr_idx_d  = clr_idx_q;
    unique case (state_q)
      StIdle: begin
        if (push) begin
          state_d    = StClear;
          clr_bank_d = bank_i;
          clr_idx_d  = '0;
        end
      end
      StClear: begin
        if (push) begin
          clr_bank_d = bank_i;
          clr_idx_d  = '0;
        end else if (change || last) begin
          state_d = StIdle;
        end else begin
          clr_idx_d = clr_idx_q + REG_BITS'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StClear;
      prev_bank_q <= '0;
      clr_bank_q  <= '0;
      clr_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_bank_q <= bank_i;
      clr_bank_q  <= clr_bank_d;
      clr_idx_q   <= clr_idx_d;
    end
  end

  assign clr_we_o   = (state_q == StClear);
  assign clr_bank_o = clr_bank_q;
  assign clr_idx_o  = clr_idx_q;
  assign busy_o     = (state_q == StClear);

endmodule

// File: rtl/register_frame_file.sv
// Banked register file: two registered read ports, one write port with bypass, frame storage
// shared with the clear engine that zero-fills each newly pushed frame.
module register_frame_file
  import pa_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned REGS_PER_BANK = DefRegsPerBank,
  parameter int unsigned BANK_BITS     = DefBankBits
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             enable_i,
  input  logic [BANK_BITS-1:0]             regBankSelect_i,
  input  logic [$clog2(REGS_PER_BANK)-1:0] readAddrA_i,
  input  logic [$clog2(REGS_PER_BANK)-1:0] readAddrB_i,
  input  logic                             writeEnable_i,
  input  logic [$clog2(REGS_PER_BANK)-1:0] writeAddr_i,
  input  logic [DATA_WIDTH-1:0]            writeData_i,
  output logic [DATA_WIDTH-1:0]            readDataA_o,
  output logic [DATA_WIDTH-1:0]            readDataB_o,
  output logic                             busy_o
);

  localparam int unsigned RegBits  = $clog2(REGS_PER_BANK);
  localparam int unsigned IdxBits  = BANK_BITS + RegBits;
  localparam int unsigned NumWords = 2 ** IdxBits;

  logic [DATA_WIDTH-1:0] mem_q [NumWords];

  logic                  clr_we;
  logic [BANK_BITS-1:0]  clr_bank;
  logic [RegBits-1:0]    clr_idx;
  logic                  busy;
  logic                  port_ok, mem_we;
  logic [IdxBits-1:0]    mem_waddr, raddr_a, raddr_b;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;

  frame_clear_fsm #(
    .REGS_PER_BANK(REGS_PER_BANK),
    .BANK_BITS    (BANK_BITS),
    .REG_BITS     (RegBits)
  ) u_clear (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .bank_i    (regBankSelect_i),
    .clr_we_o  (clr_we),
    .clr_bank_o(clr_bank),
    .clr_idx_o (clr_idx),
    .busy_o    (busy)
  );

  // Ports and the clear engine never contend: ports are only live while not busy.
  assign port_ok   = enable_i && !busy && !reset_i;
  assign mem_we    = clr_we || (port_ok && writeEnable_i);
  assign mem_waddr = clr_we ? IdxBits'(phys_idx(32'(clr_bank), 32'(clr_idx), REGS_PER_BANK))
                            : IdxBits'(phys_idx(32'(regBankSelect_i), 32'(writeAddr_i),
                                                REGS_PER_BANK));
  assign mem_wdata = clr_we ? '0 : writeData_i;
  assign raddr_a   = IdxBits'(phys_idx(32'(regBankSelect_i), 32'(readAddrA_i), REGS_PER_BANK));
  assign raddr_b   = IdxBits'(phys_idx(32'(regBankSelect_i), 32'(readAddrB_i), REGS_PER_BANK));

  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (port_ok) begin
      rd_a_d = (writeEnable_i && (writeAddr_i == readAddrA_i)) ? writeData_i : mem_q[raddr_a];
      rd_b_d = (writeEnable_i && (writeAddr_i == readAddrB_i)) ? writeData_i : mem_q[raddr_b];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign readDataA_o = rd_a_q;
  assign readDataB_o = rd_b_q;
  assign busy_o      = busy;

endmodule

// File: tb/tb_register_frame_file.sv
// Directed bench for register_frame_file: reset clear, bypass, push/pop, wrap, interrupted clears.
module tb_register_frame_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [5:0]  bank;
  logic [3:0]  ra, rb, wa;
  logic        we;
  logic [15:0] wd;
  logic [15:0] rda, rdb;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  register_frame_file dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .enable_i       (en),
    .regBankSelect_i(bank),
    .readAddrA_i    (ra),
    .readAddrB_i    (rb),
    .writeEnable_i  (we),
    .writeAddr_i    (wa),
    .writeData_i    (wd),
    .readDataA_o    (rda),
    .readDataB_o    (rdb),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles busy stays high from the current sample point, bounded.
  task automatic measure_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; en = 1'b0; bank = '0; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
    step();
    step();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL reset_busy: got %b want 1", busy);
    end
    compared++;
    if (rda !== 16'h0 || rdb !== 16'h0) begin
      mismatched++; $display("FAIL reset_rd: got %h/%h want 0000/0000", rda, rdb);
    end
    rst = 1'b0;
    measure_busy(n);
    compared++;
    if (n !== 16) begin
      mismatched++; $display("FAIL reset_busy_len: got %0d want 16", n);
    end
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i);
      rb = 4'(15 - i);
      step();
      compared++;
      if (rda !== 16'h0 || rdb !== 16'h0) begin
        mismatched++; $display("FAIL bank0_zero r%0d: got %h/%h want 0000/0000", i, rda, rdb);
      end
    end
  endtask

  task automatic test_write_bypass();
    we = 1'b1; wa = 4'd3; wd = 16'h1234; ra = 4'd0; rb = 4'd0;
    step();
    we = 1'b0; ra = 4'd3;
    step();
    compared++;
    if (rda !== 16'h1234) begin
      mismatched++; $display("FAIL wr_rd_r3: got %h want 1234", rda);
    end
    we = 1'b1; wa = 4'd5; wd = 16'hBEEF; ra = 4'd5; rb = 4'd5;
    step();
    compared++;
    if (rda !== 16'hBEEF || rdb !== 16'hBEEF) begin
      mismatched++; $display("FAIL bypass_r5: got %h/%h want beef/beef", rda, rdb);
    end
    we = 1'b0; ra = 4'd5; rb = 4'd3;
    step();
    compared++;
    if (rda !== 16'hBEEF || rdb !== 16'h1234) begin
      mismatched++; $display("FAIL stored_r5_r3: got %h/%h want beef/1234", rda, rdb);
    end
    en = 1'b0; ra = 4'd0; rb = 4'd0; we = 1'b1; wa = 4'd3; wd = 16'hFFFF;
    step();
    compared++;
    if (rda !== 16'hBEEF) begin
      mismatched++; $display("FAIL disabled_hold: got %h want beef", rda);
    end
    en = 1'b1; we = 1'b0; ra = 4'd3;
    step();
    compared++;
    if (rda !== 16'h1234) begin
      mismatched++; $display("FAIL disabled_write_dropped: got %h want 1234", rda);
    end
  endtask

  task automatic test_push_pop();
    int n;
    bank = 6'd1; we = 1'b1; wa = 4'd2; wd = 16'hAAAA; ra = 4'd0;
    step();
    we = 1'b0;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL push01_busy: got %b want 1", busy);
    end
    measure_busy(n);
    compared++;
    if (n !== 16) begin
      mismatched++; $display("FAIL push01_len: got %0d want 16", n);
    end
    ra = 4'd2;
    step();
    compared++;
    if (rda !== 16'h0) begin
      mismatched++; $display("FAIL push01_r2_cleared: got %h want 0000", rda);
    end
    we = 1'b1; wa = 4'd4; wd = 16'h5555;
    step();
    we = 1'b0; bank = 6'd2;
    step();
    measure_busy(n);
    compared++;
    if (n !== 16) begin
      mismatched++; $display("FAIL push12_len: got %0d want 16", n);
    end
    bank = 6'd1; ra = 4'd4;
    step();
    compared++;
    if (busy !== 1'b0 || rda !== 16'h5555) begin
      mismatched++; $display("FAIL pop21_keep: got busy=%b rd=%h want busy=0 rd=5555", busy, rda);
    end
  endtask

  task automatic test_wrap();
    int n;
    bank = 6'd0; we = 1'b1; wa = 4'd7; wd = 16'h7777; ra = 4'd7;
    step();
    compared++;
    if (busy !== 1'b0 || rda !== 16'h7777) begin
      mismatched++; $display("FAIL pop10: got busy=%b rd=%h want busy=0 rd=7777", busy, rda);
    end
    we = 1'b0; bank = 6'd63;
    step();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL jump063_busy: got %b want 0", busy);
    end
    bank = 6'd0;
    step();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL wrap_busy: got %b want 1", busy);
    end
    measure_busy(n);
    compared++;
    if (n !== 16) begin
      mismatched++; $display("FAIL wrap_len: got %0d want 16", n);
    end
    ra = 4'd7; rb = 4'd3;
    step();
    compared++;
    if (rda !== 16'h0 || rdb !== 16'h0) begin
      mismatched++; $display("FAIL wrap_cleared: got %h/%h want 0000/0000", rda, rdb);
    end
  endtask

  task automatic test_interrupted();
    int n;
    bank = 6'd2; we = 1'b1; wa = 4'd9; wd = 16'h9999;
    step();
    we = 1'b0; bank = 6'd0;
    step();
    bank = 6'd1;
    step();
    repeat (5) step();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL midclear_busy: got %b want 1", busy);
    end
    bank = 6'd2;
    step();
    measure_busy(n);
    compared++;
    if (n !== 16) begin
      mismatched++; $display("FAIL restart_len: got %0d want 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i);
      rb = 4'((i + 8) % 16);
      step();
      compared++;
      if (rda !== 16'h0 || rdb !== 16'h0) begin
        mismatched++; $display("FAIL bank2_zero r%0d: got %h/%h want 0000/0000", i, rda, rdb);
      end
    end
  endtask

  task automatic test_pop_midclear();
    bank = 6'd1;
    step();
    bank = 6'd2; we = 1'b1; wa = 4'd8; wd = 16'h8888; ra = 4'd8;
    step();
    compared++;
    if (busy !== 1'b1 || rda !== 16'h8888) begin
      mismatched++; $display("FAIL push_edge_op: got busy=%b rd=%h want busy=1 rd=8888", busy, rda);
    end
    wa = 4'd6; wd = 16'h6666; ra = 4'd6; rb = 4'd6;
    repeat (3) step();
    compared++;
    if (busy !== 1'b1 || rda !== 16'h8888) begin
      mismatched++; $display("FAIL busy_hold: got busy=%b rd=%h want busy=1 rd=8888", busy, rda);
    end
    we = 1'b0; bank = 6'd1;
    step();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL pop_abort: got %b want 0", busy);
    end
    bank = 6'd0;
    step();
    bank = 6'd2;
    step();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL jump02_busy: got %b want 0", busy);
    end
    ra = 4'd6; rb = 4'd8;
    step();
    compared++;
    if (rda !== 16'h0 || rdb !== 16'h8888) begin
      mismatched++; $display("FAIL partial_frame: got %h/%h want 0000/8888", rda, rdb);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_push_pop();
    test_wrap();
    test_interrupted();
    test_pop_midclear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/register_frame_file.md
# register_frame_file

Banked register file that consumes the register-bank select produced by the register frame unit. Every architectural register access is routed to the frame named by `regBankSelect_i`. On every frame push (bank index advancing by one, mod 64), the block zero-fills the newly entered frame before exposing it, stalling the pipeline through `busy_o`. It sits between the register frame unit and the execute stage: two read ports and one write port per cycle.

## Interface
- `DATA_WIDTH`, 16: register width in bits.
- `REGS_PER_BANK`, 16: registers per frame (power of two).
- `BANK_BITS`, 6: bank index width (64 frames).
- `clock_i` in 1: the block's one clock; all state updates on the rising edge.
- `reset_i` in 1: reset, synchronous and active-high.
- `enable_i` in 1: gates port reads and writes. The clear engine runs regardless.
- `regBankSelect_i` in BANK_BITS: current frame, from the register frame unit.
- `readAddrA_i`, `readAddrB_i` in log2(REGS_PER_BANK): read register indices.
- `writeEnable_i` in 1: write strobe.
- `writeAddr_i` in log2(REGS_PER_BANK): write register index.
- `writeData_i` in DATA_WIDTH: write data.
- `readDataA_o`, `readDataB_o` out DATA_WIDTH: registered read data.
- `busy_o` out 1: frame clear in progress; the upstream pipeline must stall.

## Operation
- **Storage:** 2^BANK_BITS × REGS_PER_BANK words. Physical index = {bank, reg}. Storage is not reset; frames become defined only when they are cleared or written.
- **Bank tracking:** `prevBank` register holds the last sampled `regBankSelect_i`.
  - A push is detected when `regBankSelect_i == prevBank + 1` (BANK_BITS arithmetic, so 63→0 counts as a push).
  - Any other change, including a decrement, is a pop or no-op and triggers no clear.
- **Clear FSM states:** IDLE and CLEAR. A counter `clrIdx` runs 0..REGS_PER_BANK-1, and `clrBank` holds the target frame.
  - IDLE → CLEAR on push detect. `clrBank` ← new bank; `clrIdx` ← 0.
  - In CLEAR, write 0 to {clrBank, clrIdx} each cycle and increment `clrIdx`.
  - CLEAR → IDLE after writing `clrIdx == REGS_PER_BANK-1`.
  - A push detected during CLEAR restarts the sequence on the new bank with `clrIdx` ← 0.
  - A pop during CLEAR aborts to IDLE. The partially cleared frame is left as is.
- **Reset:** `prevBank` ← 0; FSM enters CLEAR with `clrBank` = 0 and `clrIdx` = 0, so frame 0 is zeroed after reset; `readDataA_o` and `readDataB_o` ← 0; `busy_o` ← 1.
- **Port operations** (only when `enable_i` and not busy):
  - A write stores `writeData_i` at {regBankSelect_i, writeAddr_i}.
  - Reads fetch {regBankSelect_i, readAddr}.
  - Bypass: if the write strobe is active and `writeAddr_i` equals a read address in the same cycle, that read returns `writeData_i`.
- **While busy or with `enable_i` low:** port writes are dropped and the read outputs hold their previous values.

## Timing
- Read latency is 1 cycle: the address presented at edge N appears on the read output after edge N.
- A write is visible to a non-bypassed read on the next cycle.
- `busy_o` is registered. It rises the cycle after the edge on which the push is sampled and stays high for exactly REGS_PER_BANK cycles (16 by default) for an uninterrupted clear.
- A port operation presented in the same cycle a push is sampled is still performed, against the new bank.
- After reset is released, `busy_o` stays high for 16 cycles and then drops.
- Reset asserted mid-clear discards the clear and restarts clearing of frame 0.

## Structure
- **Package `pa_regfile_pkg`:** DATA_WIDTH, REGS_PER_BANK, BANK_BITS defaults; the clear-FSM state enum (IDLE, CLEAR); and a helper that packs bank and register into the physical index.
- **Sub-module `frame_clear_fsm`:** contains the push detect, `prevBank`, the counter and the state register. It outputs the clear write enable, clear address and `busy_o`.
- **Top level:** the storage array, port muxing and the bypass logic.

## Test plan
- **Reset and frame-0 clear:** assert reset for 2 cycles, then release → `busy_o` high for 16 cycles, then low. A subsequent read of every register in bank 0 returns 0.
- **Write/read with bypass:** in bank 0, write 0x1234 to r3 → next-cycle read of r3 returns 0x1234. In the same cycle, write 0xBEEF to r5 and read r5 → 0xBEEF after one cycle.
- **Push clears, pop preserves:**
  - Write 0xAAAA to bank 1 r2, then step the bank 0→1 → after 16 busy cycles, r2 in bank 1 reads 0.
  - Write 0x5555 to bank 1 r4, step 1→2, wait until not busy, step 2→1 → no busy; r4 reads 0x5555.
- **Wrap push:** step the bank 63→0 → a 16-cycle clear of bank 0.
- **Interrupted clear:** push 0→1, then push 1→2 at `clrIdx` = 5 → `busy_o` stays high for 16 more cycles and bank 2 is fully zero.
- **Pop mid-clear and dropped writes:**
  - Pop 2→1 at `clrIdx` = 3 → `busy_o` low the next cycle.
  - A write issued while busy is not stored.
